// File: rtl/product_pool_pkg.sv
// Shared types for the product allocator / recycler pair.
// Package constants size the handle fields; top-level KINDS/IDS must not exceed them.
package product_pool_pkg;

  localparam int POOL_KINDS = 2;
  localparam int POOL_IDS   = 16;
  localparam int KIND_W     = (POOL_KINDS > 1) ? $clog2(POOL_KINDS) : 1;
  localparam int ID_W       = $clog2(POOL_IDS);

  typedef logic [KIND_W-1:0] kind_t;
  typedef logic [ID_W-1:0]   id_t;

  typedef struct packed {
    kind_t kind;
    id_t   id;
  } handle_t;

  typedef enum logic {
    ERR_DOUBLE_FREE  = 1'b0,
    ERR_DOUBLE_ALLOC = 1'b1
  } err_code_e;

  typedef enum logic {
    SEED = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/product_recycler_recycle_fifo.sv
// First-word-fall-through FIFO of handles; a full FIFO refuses pushes even when
// a pop happens in the same cycle, so upstream ready can come straight from 'full'.
module recycle_fifo
  import product_pool_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  handle_t                    push_data,
  input  logic                       pop,
  output handle_t                    pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  handle_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Zero the head when empty so the recycled-handle outputs read 0 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/product_recycler.sv
// Returns released handles to the allocator, seeding every handle after reset.
// Ownership checking and error reporting exist only with PRODUCT_RECYCLER_CHECK_EN.
module product_recycler
  import product_pool_pkg::*;
#(
  parameter  int KINDS      = POOL_KINDS,
  parameter  int IDS        = POOL_IDS,
  parameter  int FIFO_DEPTH = 4,
  localparam int KW         = (KINDS > 1) ? $clog2(KINDS) : 1,
  localparam int IW         = $clog2(IDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_valid,
  input  logic [KW-1:0] alloc_kind,
  input  logic [IW-1:0] alloc_id,
  input  logic          rel_valid,
  output logic          rel_ready,
  input  logic [KW-1:0] rel_kind,
  input  logic [IW-1:0] rel_id,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [KW-1:0] rec_kind,
  output logic [IW-1:0] rec_id,
  output logic          err_valid,
  output logic          err_code,
  output logic [KW-1:0] err_kind,
  output logic [IW-1:0] err_id,
  output logic          init_done
);

  state_e          state_q, state_d;
  logic [KW-1:0]   seed_kind_q;
  logic [IW-1:0]   seed_id_q;
  logic            seed_last, seed_push;
  logic            rel_fire, rel_push;
  logic            fifo_push, fifo_full, fifo_empty;
  handle_t         fifo_in, fifo_out;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_fifo_count;

  assign seed_last = (seed_kind_q == KW'(KINDS - 1)) && (seed_id_q == IW'(IDS - 1));
  assign rel_fire  = rel_valid & rel_ready;
  assign init_done = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    seed_push = 1'b0;
    rel_ready = 1'b0;
    case (state_q)
      SEED: begin
        seed_push = ~fifo_full;
        if (seed_push && seed_last) state_d = RUN;
      end
      RUN:     rel_ready = ~fifo_full;
      default: state_d = SEED;
    endcase
  end

  // Seed walk: ids fastest, then kinds, one step per accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_kind_q <= '0;
      seed_id_q   <= '0;
    end else if (seed_push) begin
      if (seed_id_q == IW'(IDS - 1)) begin
        seed_id_q   <= '0;
        seed_kind_q <= seed_kind_q + 1'b1;
      end else begin
        seed_id_q <= seed_id_q + 1'b1;
      end
    end
  end

`ifdef PRODUCT_RECYCLER_CHECK_EN
  logic [IDS-1:0] owned_q [KINDS];
  logic           rel_owned, alloc_owned, rel_bad, alloc_bad;
  err_code_e      err_code_q;
  logic           err_valid_q;
  logic [KW-1:0]  err_kind_q;
  logic [IW-1:0]  err_id_q;

  assign rel_owned   = owned_q[rel_kind][rel_id];
  assign alloc_owned = owned_q[alloc_kind][alloc_id];
  assign rel_push    = rel_fire & rel_owned;
  assign rel_bad     = rel_fire & ~rel_owned;
  assign alloc_bad   = alloc_valid & alloc_owned;

  // The alloc set is written last so it overrides a same-cycle release clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KINDS; k++) owned_q[k] <= '0;
    end else begin
      if (rel_push)    owned_q[rel_kind][rel_id]     <= 1'b0;
      if (alloc_valid) owned_q[alloc_kind][alloc_id] <= 1'b1;
    end
  end

  // A double free outranks a same-cycle double alloc, which is then lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_DOUBLE_FREE;
      err_kind_q  <= '0;
      err_id_q    <= '0;
    end else begin
      err_valid_q <= rel_bad | alloc_bad;
      if (rel_bad) begin
        err_code_q <= ERR_DOUBLE_FREE;
        err_kind_q <= rel_kind;
        err_id_q   <= rel_id;
      end else if (alloc_bad) begin
        err_code_q <= ERR_DOUBLE_ALLOC;
        err_kind_q <= alloc_kind;
        err_id_q   <= alloc_id;
      end
    end
  end

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_kind  = err_kind_q;
  assign err_id    = err_id_q;
`else
  logic unused_alloc;

  assign unused_alloc = ^{alloc_valid, alloc_kind, alloc_id};
  assign rel_push     = rel_fire;
  assign err_valid    = 1'b0;
  assign err_code     = 1'b0;
  assign err_kind     = '0;
  assign err_id       = '0;
`endif

  assign fifo_push = seed_push | rel_push;

  always_comb begin
    fifo_in = '{kind: kind_t'(rel_kind), id: id_t'(rel_id)};
    if (seed_push) fifo_in = '{kind: kind_t'(seed_kind_q), id: id_t'(seed_id_q)};
  end

  recycle_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (rec_ready),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  assign rec_valid = ~fifo_empty;
  assign rec_kind  = KW'(fifo_out.kind);
  assign rec_id    = IW'(fifo_out.id);

endmodule

// File: doc/product_recycler.md
# product_recycler

Return-side counterpart of the product allocator. Allocation consumes object handles (kind, id) from a recycled-handle stream. This block accepts released handles from consumers, checks them against an ownership bitmap, and feeds legal handles back to the allocator through a small output FIFO. After reset it seeds the stream with every handle of every kind.

## Interface
Parameters:
- KINDS, 2: number of product kinds (≥1).
- IDS, 16: handles per kind (power of two, ≥2).
- FIFO_DEPTH, 4: output FIFO entries (≥1).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  allocator handed out a handle this cycle; no backpressure.
- alloc_kind  in  KW  kind of allocated handle; KW = max(1, $clog2(KINDS)).
- alloc_id  in  IW  id of allocated handle; IW = $clog2(IDS).
- rel_valid  in  1  release request.
- rel_ready  out  1  release accepted when rel_valid & rel_ready.
- rel_kind  in  KW  released kind.
- rel_id  in  IW  released id.
- rec_valid  out  1  recycled handle available.
- rec_ready  in  1  allocator consumes the handle.
- rec_kind  out  KW  recycled kind.
- rec_id  out  IW  recycled id.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  1  0 = double free, 1 = double alloc.
- err_kind  out  KW  offending kind.
- err_id  out  IW  offending id.
- init_done  out  1  seeding complete.

## Operation
- FSM states: SEED → RUN. Reset enters SEED.
- SEED:
  - Counter walks kind 0 ids 0..IDS-1, then kind 1, through kind KINDS-1.
  - One push per cycle while the FIFO is not full.
  - rel_ready = 0.
  - alloc_valid is still honoured.
  - After the last push, move to RUN. init_done = 1 from the next cycle on.
- RUN: rel_ready = ~fifo_full. A pop in the same cycle does not free space early.
- Ownership bitmap: KINDS×IDS bits, all 0 at reset.
- Accepted release, owned bit = 1: clear the bit and push the handle into the FIFO.
- Accepted release, owned bit = 0:
  - Drop the handle; nothing is pushed.
  - err_valid = 1 next cycle with err_code = 0 and the offending kind/id.
- alloc_valid with owned bit = 1: bit stays 1; err_valid next cycle with err_code = 1.
- Same cycle alloc and release:
  - The release check uses the registered bitmap.
  - Update is bit_next = (bit & ~rel_clear) | alloc_set, so alloc wins on the same handle.
  - If both raise errors, the double-free error is reported first. The double-alloc error is dropped and the same-cycle release error has priority.
- FIFO: first-word-fall-through. A push and a pop in the same cycle while not empty are both performed.
- Reset mid-operation:
  - FIFO, bitmap, errors and FSM clear immediately.
  - Seeding restarts from kind 0 id 0.

## Timing
- Reset values: rel_ready 0, rec_valid 0, rec_kind/rec_id 0, err_valid 0, err_code/err_kind/err_id 0, init_done 0.
- Release-to-rec latency: an accepted release appears on rec_valid the next cycle when the FIFO was empty.
- Error latency: 1 cycle after the offending handshake or alloc; err_valid is high for exactly one cycle.
- Seeding takes KINDS×IDS cycles when rec_ready = 1 throughout, and stalls cycle-for-cycle while the FIFO is full.
- rec_kind and rec_id are stable while rec_valid & ~rec_ready.

## Configuration
- PRODUCT_RECYCLER_CHECK_EN defined: ownership bitmap and error reporting are present, as described above.
- Not defined:
  - No bitmap.
  - Every accepted release is pushed.
  - alloc_* inputs are ignored.
  - err_valid, err_code, err_kind and err_id are tied to 0.

## Structure
- Shared package product_pool_pkg:
  - kind_t and id_t typedefs (parameter-sized via package constants).
  - handle_t struct {kind, id}.
  - err_code_e enum {ERR_DOUBLE_FREE, ERR_DOUBLE_ALLOC}.
  - state_e {SEED, RUN}.
- One sub-module, recycle_fifo: parameterised first-word-fall-through FIFO of handle_t, with full/empty flags and a count.
- Top level holds the FSM, seed counter, bitmap and error register.

## Test plan
- Reset with KINDS=2, IDS=16, FIFO_DEPTH=4, rec_ready=1:
  - 32 handles emerge in the order (0,0)..(0,15),(1,0)..(1,15).
  - init_done rises the cycle after the last push.
  - rel_ready stays 0 until then.
- alloc (1,5), then release (1,5): rec (1,5) appears 1 cycle after the handshake; err_valid stays 0.
- Release (0,3) never allocated: handshake completes; one-cycle err_valid with code 0, kind 0, id 3; rec_valid stays 0.
- Double alloc (0,7) twice: second alloc produces err_valid with code 1, kind 0, id 7. A single release of (0,7) is then recycled without error.
- Backpressure with rec_ready=0:
  - Allocate and release 5 handles; the first 4 fill the FIFO.
  - rel_ready drops and the 5th waits.
  - Raise rec_ready: the 5th is accepted one cycle after the first pop.
- Reset asserted mid-RUN with 3 handles queued: rec_valid goes 0 immediately, init_done goes 0, and seeding restarts at (0,0).
